spi_shift_engine: RTL and testbench

- Serial datapath of the SPI master, sitting between the TX FIFO (which it pops) and the RX FIFO (which it pushes).
- Takes words from the TX FIFO and shifts them out on MOSI while sampling MISO.
- Generates SCLK and CS_n for modes 0-3, with programmable word length and bit order.
- Runs back-to-back frames under one CS_n assertion while TX data is available.
- The TX FIFO is instantiated with combinational read data, so txData is valid whenever txEmpty=0.

---
 rtl/spi_shift_engine.sv | 196 +++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
// Serial datapath of an SPI master. Pops words from a TX FIFO (combinational
// read data), shifts them out on mosi while sampling miso, and pushes the
// received words into an RX FIFO. Supports SPI modes 0-3, word lengths of
// 1..DATA_BUS_SIZE bits and either bit order. Consecutive words run back to
// back under a single csN assertion while TX data is available.
//
// Ports:
//   clock, areset (async, active high), sreset (sync, aborts any frame)
//   enable                      permits starting new words
//   clockDivider                SCLK half-period = clockDivider+1 clocks
//   cpol, cpha, lsbFirst        SPI mode and bit order
//   wordLength                  bits per word minus 1
//   txEmpty, txData, txPop      TX FIFO side
//   rxFull, rxData, rxPush      RX FIFO side
//   sclk, mosi, miso, csN       SPI pins
//   busy                        high whenever not IDLE
//   rxOverrun                   sticky: a word was dropped because rxFull=1
// -----------------------------------------------------------------------------
module spi_shift_engine #(
   parameter int DATA_BUS_SIZE   = 32,
   parameter int CLOCK_DIV_WIDTH = 8
) (
   input  logic                               clock,
   input  logic                               areset,
   input  logic                               sreset,
   input  logic                               enable,
   input  logic [CLOCK_DIV_WIDTH-1:0]         clockDivider,
   input  logic                               cpol,
   input  logic                               cpha,
   input  logic                               lsbFirst,
   input  logic [$clog2(DATA_BUS_SIZE)-1:0]   wordLength,
   input  logic                               txEmpty,
   input  logic [DATA_BUS_SIZE-1:0]           txData,
   output logic                               txPop,
   input  logic                               rxFull,
   output logic [DATA_BUS_SIZE-1:0]           rxData,
   output logic                               rxPush,
   output logic                               sclk,
   output logic                               mosi,
   input  logic                               miso,
   output logic                               csN,
   output logic                               busy,
   output logic                               rxOverrun
);

   localparam int WL_W = $clog2(DATA_BUS_SIZE);
   localparam int TC_W = WL_W + 1;   // counts 0 .. 2*(wordLength+1)-1 ticks

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, HOLD = 2'd3} state_t;

   state_t                     state_r, state_next_s;
   logic [CLOCK_DIV_WIDTH-1:0] div_cnt_r, div_r;
   logic [TC_W-1:0]            tick_cnt_r;
   logic [DATA_BUS_SIZE-1:0]   tx_word_r, rx_sr_r, rx_data_r, rx_shift_s;
   logic [WL_W-1:0]            wl_r, drive_idx_s;
   logic                       cpol_r, cpha_r, lsb_r, sclk_r, mosi_r;
   logic                       done_r, overrun_r;
   logic                       tick_s, last_tick_s, start_s, chain_s, load_s;
   logic                       drive_s, sample_s;

   // Bit n (0 = first on the wire) of a word for the given length and bit order
   function automatic logic bit_at(input logic [DATA_BUS_SIZE-1:0] w,
                                   input logic [WL_W-1:0] wl,
                                   input logic lsb,
                                   input logic [WL_W-1:0] n);
      logic [WL_W-1:0] idx;
      idx = lsb ? n : (wl - n);
      return w[idx];
   endfunction

   assign tick_s      = (div_cnt_r == {CLOCK_DIV_WIDTH{1'b0}});
   assign last_tick_s = (state_r == SHIFT) && tick_s && (tick_cnt_r == {wl_r, 1'b1});
   assign start_s     = (state_r == IDLE) && enable && !txEmpty && !sreset;
   // Chaining decision is taken on the last tick so the next word keeps the SCLK cadence
   assign chain_s     = last_tick_s && enable && !txEmpty && !sreset;
   assign load_s      = start_s || chain_s;

   // tick_cnt_r[0]==0 means the coming tick is odd (leading edge)
   assign sample_s    = (state_r == SHIFT) && tick_s && (cpha_r ? tick_cnt_r[0] : !tick_cnt_r[0]);
   assign drive_s     = (state_r == SHIFT) && tick_s &&
                        (cpha_r ? !tick_cnt_r[0] : (tick_cnt_r[0] && !last_tick_s));
   // cpha=0 drives bit t/2 on even tick t; cpha=1 drives bit (t-1)/2 on odd tick t
   assign drive_idx_s = cpha_r ? tick_cnt_r[TC_W-1:1] : (tick_cnt_r[TC_W-1:1] + WL_W'(1));

   // msb-first enters at bit 0; lsb-first enters at bit wordLength and moves down
   assign rx_shift_s  = lsb_r ? ((rx_sr_r >> 1) | ({{(DATA_BUS_SIZE-1){1'b0}}, miso} << wl_r))
                              : {rx_sr_r[DATA_BUS_SIZE-2:0], miso};

   assign txPop     = load_s;
   assign rxPush    = done_r && !rxFull && !sreset;
   assign rxData    = rx_data_r;
   assign sclk      = (state_r == IDLE) ? cpol : sclk_r;
   assign mosi      = mosi_r;
   assign csN       = (state_r == IDLE);
   assign busy      = (state_r != IDLE);
   assign rxOverrun = overrun_r;

   // State register
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         state_r <= IDLE;
      end else if (sreset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) state_next_s = SETUP;
            else         state_next_s = IDLE;
         end
         SETUP: begin
            if (tick_s) state_next_s = SHIFT;
            else        state_next_s = SETUP;
         end
         SHIFT: begin
            if (chain_s)          state_next_s = SHIFT;
            else if (last_tick_s) state_next_s = HOLD;
            else                  state_next_s = SHIFT;
         end
         HOLD: begin
            if (tick_s) state_next_s = IDLE;
            else        state_next_s = HOLD;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Datapath: divider, tick counter, shift registers, config latch and flags
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         div_cnt_r <= {CLOCK_DIV_WIDTH{1'b0}}; div_r <= {CLOCK_DIV_WIDTH{1'b0}};
         tick_cnt_r <= {TC_W{1'b0}};           wl_r <= {WL_W{1'b0}};
         tx_word_r <= {DATA_BUS_SIZE{1'b0}};   rx_sr_r <= {DATA_BUS_SIZE{1'b0}};
         rx_data_r <= {DATA_BUS_SIZE{1'b0}};
         cpol_r <= 1'b0; cpha_r <= 1'b0; lsb_r <= 1'b0; sclk_r <= 1'b0; mosi_r <= 1'b0;
         done_r <= 1'b0; overrun_r <= 1'b0;
      end else if (sreset) begin
         div_cnt_r <= {CLOCK_DIV_WIDTH{1'b0}}; div_r <= {CLOCK_DIV_WIDTH{1'b0}};
         tick_cnt_r <= {TC_W{1'b0}};           wl_r <= {WL_W{1'b0}};
         tx_word_r <= {DATA_BUS_SIZE{1'b0}};   rx_sr_r <= {DATA_BUS_SIZE{1'b0}};
         rx_data_r <= {DATA_BUS_SIZE{1'b0}};
         cpol_r <= 1'b0; cpha_r <= 1'b0; lsb_r <= 1'b0; sclk_r <= 1'b0; mosi_r <= 1'b0;
         done_r <= 1'b0; overrun_r <= 1'b0;
      end else begin
         done_r <= last_tick_s;
         if (done_r && rxFull) overrun_r <= 1'b1;
         // cpha=1 takes its final sample on the last tick itself
         if (last_tick_s) rx_data_r <= sample_s ? rx_shift_s : rx_sr_r;
         if (load_s) begin
            tx_word_r  <= txData;
            rx_sr_r    <= {DATA_BUS_SIZE{1'b0}};
            cpol_r     <= cpol;
            cpha_r     <= cpha;
            lsb_r      <= lsbFirst;
            wl_r       <= wordLength;
            div_r      <= clockDivider;
            div_cnt_r  <= clockDivider;
            tick_cnt_r <= {TC_W{1'b0}};
            sclk_r     <= cpol;
            mosi_r     <= cpha ? mosi_r : bit_at(txData, wordLength, lsbFirst, {WL_W{1'b0}});
         end else begin
            case (state_r)
               IDLE: begin
                  mosi_r    <= 1'b0;
                  div_cnt_r <= div_r;
               end
               SETUP, HOLD: begin
                  if (tick_s) div_cnt_r <= div_r;
                  else        div_cnt_r <= div_cnt_r - CLOCK_DIV_WIDTH'(1);
               end
               SHIFT: begin
                  if (tick_s) begin
                     div_cnt_r  <= div_r;
                     sclk_r     <= ~sclk_r;
                     tick_cnt_r <= tick_cnt_r + TC_W'(1);
                     if (sample_s) rx_sr_r <= rx_shift_s;
                     if (drive_s)  mosi_r  <= bit_at(tx_word_r, wl_r, lsb_r, drive_idx_s);
                  end else begin
                     div_cnt_r <= div_cnt_r - CLOCK_DIV_WIDTH'(1);
                  end
               end
               default: div_cnt_r <= div_r;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_engine
// Directed bench for spi_shift_engine. A small TX FIFO model feeds the DUT,
// miso is looped back to mosi, and every word expected on the RX side is
// queued when its stimulus is written and compared when rxPush fires.
// -----------------------------------------------------------------------------
module tb_spi_shift_engine;

   logic        clock = 1'b0;
   logic        areset, sreset, enable, cpol, cpha, lsbFirst, rxFull;
   logic [7:0]  clockDivider;
   logic [4:0]  wordLength;
   logic        txEmpty, txPop, rxPush, sclk, mosi, miso, csN, busy, rxOverrun;
   logic [31:0] txData, rxData;

   logic [31:0] tx_mem [0:15];
   int          rd_ptr = 0, wr_ptr = 0;
   int          pop_cnt = 0, push_cnt = 0;
   int          checks = 0, errors = 0;
   logic [31:0] exp_q [$];

   // frame observations gathered by run_frame
   int          cs_low, pulses, cs_rises, min_iv, max_iv, nbits;
   logic        first_bit;
   logic [63:0] mosi_bits;
   int          p0, q0, ntog;
   logic        prev_s;

   spi_shift_engine #(.DATA_BUS_SIZE(32), .CLOCK_DIV_WIDTH(8)) dut (
      .clock(clock), .areset(areset), .sreset(sreset), .enable(enable),
      .clockDivider(clockDivider), .cpol(cpol), .cpha(cpha), .lsbFirst(lsbFirst),
      .wordLength(wordLength), .txEmpty(txEmpty), .txData(txData), .txPop(txPop),
      .rxFull(rxFull), .rxData(rxData), .rxPush(rxPush), .sclk(sclk), .mosi(mosi),
      .miso(miso), .csN(csN), .busy(busy), .rxOverrun(rxOverrun)
   );

   always #5 clock = ~clock;

   assign miso    = mosi;
   assign txEmpty = (rd_ptr == wr_ptr);
   assign txData  = tx_mem[rd_ptr % 16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_tx(input logic [31:0] d);
      tx_mem[wr_ptr % 16] = d;
      wr_ptr++;
   endtask

   // TX FIFO model: advances its read pointer on each pop strobe
   always @(posedge clock) begin
      if (txPop) begin
         chk("pop_when_empty", {63'd0, txEmpty}, 64'd0);
         pop_cnt++;
         rd_ptr <= rd_ptr + 1;
      end
   end

   // RX scoreboard: compare every pushed word with the oldest expected one
   always @(negedge clock) begin
      if (rxPush) begin
         push_cnt++;
         chk("push_when_full", {63'd0, rxFull}, 64'd0);
         if (exp_q.size() == 0) chk("unexpected_push", {32'd0, rxData}, 64'hFFFF_FFFF_FFFF_FFFF);
         else                   chk("rx_data", {32'd0, rxData}, {32'd0, exp_q.pop_front()});
      end
   end

   // Follow one frame until the DUT returns idle, recording SCLK/csN/mosi activity
   task automatic run_frame(input int max_cyc);
      int   cyc, last_t, iv;
      logic prev_sclk, prev_cs, seen;
      cs_low = 0; pulses = 0; cs_rises = 0; min_iv = 1000; max_iv = 0;
      nbits = 0; first_bit = 1'b0; mosi_bits = 64'd0;
      prev_sclk = sclk; prev_cs = csN; last_t = -1; seen = 1'b0; cyc = 0;
      while (cyc < max_cyc) begin
         @(negedge clock);
         cyc++;
         if (busy) seen = 1'b1;
         if (!csN) cs_low++;
         if (csN && !prev_cs) cs_rises++;
         if (sclk !== prev_sclk) begin
            if (last_t >= 0) begin
               iv = cyc - last_t;
               if (iv < min_iv) min_iv = iv;
               if (iv > max_iv) max_iv = iv;
            end
            last_t = cyc;
            if (sclk !== cpol) begin
               pulses++;
               if (nbits == 0) first_bit = mosi;
               mosi_bits = {mosi_bits[62:0], mosi};
               nbits++;
            end
         end
         prev_sclk = sclk;
         prev_cs   = csN;
         if (seen && !busy) break;
      end
      chk("frame_timeout", {63'd0, (seen && !busy)}, 64'd1);
   endtask

   initial begin
      areset = 1'b1; sreset = 1'b0; enable = 1'b0; cpol = 1'b0; cpha = 1'b0;
      lsbFirst = 1'b0; rxFull = 1'b0; clockDivider = 8'd0; wordLength = 5'd7;
      repeat (3) @(negedge clock);
      areset = 1'b0;
      @(negedge clock);

      // reset state
      chk("rst_csN", {63'd0, csN}, 64'd1);
      chk("rst_sclk", {63'd0, sclk}, 64'd0);
      chk("rst_mosi", {63'd0, mosi}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_overrun", {63'd0, rxOverrun}, 64'd0);
      chk("rst_rxdata", {32'd0, rxData}, 64'd0);
      chk("rst_txpop", {63'd0, txPop}, 64'd0);

      // mode 0, div 0, 8-bit msb-first 0xA5
      cpol = 1'b0; cpha = 1'b0; clockDivider = 8'd0; wordLength = 5'd7; lsbFirst = 1'b0;
      push_tx(32'hA5); exp_q.push_back(32'h0000_00A5);
      p0 = pop_cnt; q0 = push_cnt; enable = 1'b1;
      run_frame(200);
      enable = 1'b0;
      chk("t1_pops", pop_cnt - p0, 64'd1);
      chk("t1_pushes", push_cnt - q0, 64'd1);
      chk("t1_cs_low", cs_low, 64'd18);
      chk("t1_pulses", pulses, 64'd8);
      chk("t1_mosi_seq", {56'd0, mosi_bits[7:0]}, 64'hA5);
      chk("t1_half_period", min_iv, 64'd1);
      chk("t1_csN_end", {63'd0, csN}, 64'd1);

      // mode 3, div 3, 16-bit lsb-first, two words back to back
      cpol = 1'b1; cpha = 1'b1; clockDivider = 8'd3; wordLength = 5'd15; lsbFirst = 1'b1;
      @(negedge clock);
      chk("t2_sclk_idle", {63'd0, sclk}, 64'd1);
      push_tx(32'h1234); push_tx(32'hBEEF);
      exp_q.push_back(32'h0000_1234); exp_q.push_back(32'h0000_BEEF);
      p0 = pop_cnt; q0 = push_cnt; enable = 1'b1;
      run_frame(1000);
      enable = 1'b0;
      chk("t2_pops", pop_cnt - p0, 64'd2);
      chk("t2_pushes", push_cnt - q0, 64'd2);
      chk("t2_cs_low", cs_low, 64'd264);
      chk("t2_cs_rises", cs_rises, 64'd1);
      chk("t2_pulses", pulses, 64'd32);
      chk("t2_min_half", min_iv, 64'd4);
      chk("t2_max_half", max_iv, 64'd4);

      // RX FIFO full at end of word -> overrun, sticky until reset
      cpol = 1'b0; cpha = 1'b0; clockDivider = 8'd1; wordLength = 5'd7; lsbFirst = 1'b0;
      rxFull = 1'b1;
      push_tx(32'h3C);
      q0 = push_cnt; enable = 1'b1;
      run_frame(300);
      enable = 1'b0;
      chk("t3_no_push", push_cnt - q0, 64'd0);
      chk("t3_overrun", {63'd0, rxOverrun}, 64'd1);
      rxFull = 1'b0;
      repeat (5) @(negedge clock);
      chk("t3_overrun_held", {63'd0, rxOverrun}, 64'd1);
      areset = 1'b1;
      @(negedge clock);
      areset = 1'b0;
      @(negedge clock);
      chk("t3_overrun_clr", {63'd0, rxOverrun}, 64'd0);

      // sreset at SHIFT tick 5 of an 8-bit frame
      push_tx(32'h5A); push_tx(32'h77);
      p0 = pop_cnt; q0 = push_cnt; enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      ntog = 0; prev_s = sclk;
      for (int i = 0; i < 200 && ntog < 5; i++) begin
         @(negedge clock);
         if (sclk !== prev_s) ntog++;
         prev_s = sclk;
      end
      chk("t4_reach_tick5", ntog, 64'd5);
      sreset = 1'b1;
      @(negedge clock);
      chk("t4_csN", {63'd0, csN}, 64'd1);
      chk("t4_sclk", {63'd0, sclk}, 64'd0);
      chk("t4_busy", {63'd0, busy}, 64'd0);
      sreset = 1'b0;
      repeat (4) @(negedge clock);
      chk("t4_no_push", push_cnt - q0, 64'd0);
      chk("t4_pops", pop_cnt - p0, 64'd1);
      chk("t4_fifo_level", wr_ptr - rd_ptr, 64'd1);
      // drain the word left behind
      exp_q.push_back(32'h0000_0077);
      q0 = push_cnt; enable = 1'b1;
      run_frame(300);
      enable = 1'b0;
      chk("t4_drain_push", push_cnt - q0, 64'd1);

      // mode 1, 32-bit word
      cpol = 1'b0; cpha = 1'b1; clockDivider = 8'd0; wordLength = 5'd31; lsbFirst = 1'b0;
      push_tx(32'h8000_0001); exp_q.push_back(32'h8000_0001);
      q0 = push_cnt; enable = 1'b1;
      run_frame(500);
      enable = 1'b0;
      chk("t5_pulses", pulses, 64'd32);
      chk("t5_first_bit", {63'd0, first_bit}, 64'd1);
      chk("t5_mosi_seq", {32'd0, mosi_bits[31:0]}, 64'h8000_0001);
      chk("t5_pushes", push_cnt - q0, 64'd1);

      // enable dropped mid-word with two words queued
      cpol = 1'b0; cpha = 1'b0; clockDivider = 8'd1; wordLength = 5'd7; lsbFirst = 1'b0;
      push_tx(32'h11); push_tx(32'h22); exp_q.push_back(32'h0000_0011);
      p0 = pop_cnt; q0 = push_cnt; enable = 1'b1;
      repeat (6) @(negedge clock);
      enable = 1'b0;
      run_frame(300);
      chk("t6_pops", pop_cnt - p0, 64'd1);
      chk("t6_pushes", push_cnt - q0, 64'd1);
      chk("t6_csN_end", {63'd0, csN}, 64'd1);
      chk("t6_fifo_level", wr_ptr - rd_ptr, 64'd1);
      exp_q.push_back(32'h0000_0022);
      q0 = push_cnt; enable = 1'b1;
      run_frame(300);
      enable = 1'b0;
      chk("t6_drain_push", push_cnt - q0, 64'd1);

      repeat (3) @(negedge clock);
      chk("scoreboard_empty", exp_q.size(), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
